// File: rtl/plant_sim.sv
// Pressure-vessel plant model driven by a PLC pump/vent command, updated once per prescaler tick.
// Optional sensor noise (16-bit LFSR on the low nibble) is enabled by defining PLANT_NOISE_EN.
module plant_sim #(
  parameter int          PRESC         = 4,
  parameter logic [15:0] INIT_PRESSURE = 16'hBFFF,
  parameter logic [15:0] RISE_STEP     = 16'h0100,
  parameter logic [15:0] LEAK_STEP     = 16'h0010,
  parameter logic [15:0] VENT_STEP     = 16'h0400,
  parameter logic [15:0] OVP_LIMIT     = 16'hF000,
  parameter int          FAULT_TICKS   = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        motor_in,
  input  logic        vent_in,
  output logic [15:0] pressure_out,
  output logic        tick_out,
  output logic        overpressure_out,
  output logic [1:0]  state_out
);

  localparam int CW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int OW = $clog2(FAULT_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESC - 1);
  localparam logic [OW-1:0] OVC_LAST = OW'(FAULT_TICKS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PUMP  = 2'b01,
    S_OVER  = 2'b10,
    S_FAULT = 2'b11
  } state_t;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic                tick_q, tick_d;
  logic [15:0]         press_q, press_d;
  logic                ovp_q, ovp_d;
  state_t              state_q, state_d;
  logic [OW-1:0]       ovc_q, ovc_d;
  logic                pump_act;
  logic signed [17:0]  delta;
  logic signed [17:0]  sum;

  always_comb begin
    cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    // tick is registered so it is low during reset even when PRESC is 1
    tick_d   = (cnt_d == CNT_LAST);
    pump_act = motor_in && (state_q != S_FAULT);
    delta    = (pump_act ? $signed({2'b00, RISE_STEP}) : 18'sd0)
             - $signed({2'b00, LEAK_STEP})
             - (vent_in ? $signed({2'b00, VENT_STEP}) : 18'sd0);
    sum      = $signed({2'b00, press_q}) + delta;

    press_d = press_q;
    ovp_d   = ovp_q;
    state_d = state_q;
    ovc_d   = ovc_q;

    if (tick_q) begin
      if (sum < 18'sd0)             press_d = 16'h0000;
      else if (sum > 18'sh0FFFF)    press_d = 16'hFFFF;
      else                          press_d = sum[15:0];
      ovp_d = (press_d >= OVP_LIMIT);

      case (state_q)
        S_IDLE: if (motor_in) state_d = S_PUMP;
        S_PUMP: begin
          if (!motor_in) state_d = S_IDLE;
          else if (ovp_d) begin
            state_d = S_OVER;
            ovc_d   = '0;
          end
        end
        S_OVER: begin
          if (!motor_in)  state_d = S_IDLE;
          else if (!ovp_d) state_d = S_PUMP;
          else begin
            ovc_d = ovc_q + 1'b1;
            if (ovc_d == OVC_LAST) state_d = S_FAULT;
          end
        end
        default: state_d = S_FAULT;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      press_q <= INIT_PRESSURE;
      ovp_q   <= (INIT_PRESSURE >= OVP_LIMIT);
      state_q <= S_IDLE;
      ovc_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      press_q <= press_d;
      ovp_q   <= ovp_d;
      state_q <= state_d;
      ovc_q   <= ovc_d;
    end
  end

`ifdef PLANT_NOISE_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (tick_q) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end

  assign pressure_out = press_q ^ {12'b0, lfsr_q[3:0]};
`else
  assign pressure_out = press_q;
`endif

  assign tick_out         = tick_q;
  assign overpressure_out = ovp_q;
  assign state_out        = state_q;

endmodule

// File: tb/tb_plant_sim.sv
// Bench for plant_sim: three instances (nominal, near-empty, near-full) checked every cycle
// against an arithmetic plant model, plus directed literal expectations.
module tb_plant_sim;

  localparam int PRESC = 4;
  localparam int OVP   = 'hF000;

  logic        clk, rst, motor, vent;
  logic [15:0] p0, p1, p2;
  logic        t0, t1, t2, o0, o1, o2;
  logic [1:0]  s0, s1, s2;

  int n_chk = 0;
  int n_err = 0;

  plant_sim #(.PRESC(PRESC)) u0 (
    .clk_in(clk), .rst_in(rst), .motor_in(motor), .vent_in(vent),
    .pressure_out(p0), .tick_out(t0), .overpressure_out(o0), .state_out(s0));
  plant_sim #(.PRESC(PRESC), .INIT_PRESSURE(16'h0005)) u1 (
    .clk_in(clk), .rst_in(rst), .motor_in(motor), .vent_in(vent),
    .pressure_out(p1), .tick_out(t1), .overpressure_out(o1), .state_out(s1));
  plant_sim #(.PRESC(PRESC), .INIT_PRESSURE(16'hFF80), .FAULT_TICKS(15)) u2 (
    .clk_in(clk), .rst_in(rst), .motor_in(motor), .vent_in(vent),
    .pressure_out(p2), .tick_out(t2), .overpressure_out(o2), .state_out(s2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural plant model ----------------
  int          ph;
  int          tick_cnt;
  int          mp[3];
  int          ms[3];   // 0 idle, 1 pumping, 2 overrun, 3 fault
  int          mo[3];
  bit          movp[3];
  logic [15:0] lf;

  function automatic int init_of(int i);
    case (i)
      0:       return 'hBFFF;
      1:       return 'h0005;
      default: return 'hFF80;
    endcase
  endfunction

  function automatic int ft_of(int i);
    return (i == 2) ? 15 : 8;
  endfunction

  function automatic int noise();
`ifdef PLANT_NOISE_EN
    return int'(lf[3:0]);
`else
    return 0;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = 0;
      lf = 16'hACE1;
      for (int i = 0; i < 3; i++) begin
        mp[i] = init_of(i); ms[i] = 0; mo[i] = 0; movp[i] = (mp[i] >= OVP);
      end
    end else begin
      if (ph == PRESC - 1) begin
        for (int i = 0; i < 3; i++) begin
          int np;
          np = mp[i] + ((motor && ms[i] != 3) ? 'h100 : 0) - 'h10 - (vent ? 'h400 : 0);
          if (np < 0) np = 0;
          if (np > 'hFFFF) np = 'hFFFF;
          mp[i] = np;
          movp[i] = (np >= OVP);
          if (ms[i] == 0) begin
            if (motor) ms[i] = 1;
          end else if (ms[i] == 1) begin
            if (!motor) ms[i] = 0;
            else if (movp[i]) begin ms[i] = 2; mo[i] = 0; end
          end else if (ms[i] == 2) begin
            if (!motor) ms[i] = 0;
            else if (!movp[i]) ms[i] = 1;
            else begin
              mo[i]++;
              if (mo[i] >= ft_of(i)) ms[i] = 3;
            end
          end
        end
        lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
        tick_cnt++;
      end
      ph = (ph + 1) % PRESC;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input int i, input logic [15:0] p, input logic t, input logic o,
                     input logic [1:0] s);
    chk($sformatf("u%0d.pressure", i), 32'(p), 32'((mp[i] ^ noise()) & 'hFFFF));
    chk($sformatf("u%0d.tick", i), 32'(t), 32'(ph == PRESC - 1 && !rst));
    chk($sformatf("u%0d.ovp", i), 32'(o), 32'(movp[i]));
    chk($sformatf("u%0d.state", i), 32'(s), 32'(ms[i]));
  endtask

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      cmp(0, p0, t0, o0, s0);
      cmp(1, p1, t1, o1, s1);
      cmp(2, p2, t2, o2, s2);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    int tgt;
    int guard;
    tgt = tick_cnt + n;
    guard = 0;
    while (tick_cnt < tgt && guard < n * PRESC + 8) begin
      @(negedge clk);
      guard++;
    end
    if (tick_cnt < tgt) begin
      n_chk++;
      n_err++;
      $display("FAIL run_ticks: got %0d ticks expected %0d", tick_cnt - tgt + n, n);
    end
  endtask

  logic [7:0] tick_pat;

  initial begin
    tick_cnt = 0;
    rst = 1'b1; motor = 1'b0; vent = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;

    // reset values and tick cadence (cycles 4, 8 after release)
    #1;
    chk("rst.pressure", 32'(p0), 32'('hBFFF ^ noise()));
    chk("rst.state", 32'(s0), 32'd0);
    chk("rst.ovp", 32'(o0), 32'd0);
    chk("rst.ovp_full", 32'(o2), 32'd1);
    tick_pat = 8'b1000_1000;
    chk("tick.cycle1", 32'(t0), 32'(tick_pat[0]));
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("tick.cycle%0d", k + 1), 32'(t0), 32'(tick_pat[k]));
    end

    // single pump tick
    do_reset();
    motor = 1'b1;
    run_ticks(1);
    motor = 1'b0;
    chk("pump1.pressure", 32'(p0), 32'('hC0EF ^ noise()));
    chk("pump1.state", 32'(s0), 32'd1);

    // floor clamp
    do_reset();
    run_ticks(1);
    chk("floor.t1", 32'(p1), 32'(0 ^ noise()));
    run_ticks(1);
    chk("floor.t2", 32'(p1), 32'(0 ^ noise()));
    vent = 1'b1;
    run_ticks(2);
    chk("floor.vent", 32'(p1), 32'(0 ^ noise()));
    vent = 1'b0;

    // pump and vent together
    do_reset();
    motor = 1'b1; vent = 1'b1;
    run_ticks(1);
    motor = 1'b0; vent = 1'b0;
    chk("pumpvent.pressure", 32'(p0), 32'('hBCEF ^ noise()));

    // climb to overpressure, overrun, fault; ceiling clamp on the near-full instance
    do_reset();
    motor = 1'b1;
    run_ticks(1);
    chk("ceil.t1", 32'(p2), 32'('hFFFF ^ noise()));
    run_ticks(2);
    chk("ceil.t3", 32'(p2), 32'('hFFFF ^ noise()));
    run_ticks(48);
    chk("climb51.pressure", 32'(p0), 32'('hEFCF ^ noise()));
    chk("climb51.ovp", 32'(o0), 32'd0);
    chk("climb51.state", 32'(s0), 32'd1);
    run_ticks(1);
    chk("climb52.pressure", 32'(p0), 32'('hF0BF ^ noise()));
    chk("climb52.ovp", 32'(o0), 32'd1);
    chk("climb52.state", 32'(s0), 32'd2);
    run_ticks(7);
    chk("overrun7.state", 32'(s0), 32'd2);
    run_ticks(1);
    chk("overrun8.state", 32'(s0), 32'd3);
    chk("overrun8.pressure", 32'(p0), 32'('hF83F ^ noise()));
    run_ticks(1);
    chk("fault.leak", 32'(p0), 32'('hF82F ^ noise()));
    chk("fault.sticky", 32'(s0), 32'd3);

    // asynchronous reset mid-prescale while in FAULT
    begin
      int g;
      g = 0;
      while (ph != 1 && g < 2 * PRESC) begin
        @(negedge clk);
        g++;
      end
    end
    #2 rst = 1'b1;
    #1;
    chk("arst.pressure", 32'(p0), 32'('hBFFF ^ noise()));
    chk("arst.state", 32'(s0), 32'd0);
    chk("arst.ovp", 32'(o0), 32'd0);
    chk("arst.tick", 32'(t0), 32'd0);
    chk("arst.ovp_full", 32'(o2), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    motor = 1'b0;

    // randomized operation with occasional asynchronous resets
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      motor = ($urandom_range(0, 15) != 0);
      vent  = ($urandom_range(0, 7) == 0);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 399) == 0) begin
        #($urandom_range(1, 4));
        rst = 1'b1;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
